// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, majority-voted, one-entry valid/ready output.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned MID = OVERSAMPLE / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  logic                 rx_meta, rx_s;
  logic [2:0]           state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q, stop_err_q;

  logic vote_c, dec_c, end_c;
  logic shift_c, par_chk_c, stop_chk_c, done_c;

  assign vote_c = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign dec_c  = tick && (cnt == CNT_DEC);
  assign end_c  = tick && (cnt == CNT_LAST);

  // Two-flop synchronizer on the serial line, idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register and per-bit counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shift_c      = 1'b0;
    par_chk_c    = 1'b0;
    stop_chk_c   = 1'b0;
    done_c       = 1'b0;

    if (tick && (state != ST_IDLE) && (state != ST_BREAK)) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (tick && !rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (dec_c && vote_c) begin
          state_nxt = ST_IDLE;
        end else if (end_c) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (dec_c) shift_c = 1'b1;
        if (end_c) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt  = '0;
            stop_cnt_nxt = 1'b0;
            state_nxt    = PAR_EN ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      ST_PAR: begin
        if (dec_c) par_chk_c = 1'b1;
        if (end_c) begin
          state_nxt    = ST_STOP;
          stop_cnt_nxt = 1'b0;
        end
      end
      ST_STOP: begin
        // Last stop bit completes at its decision point to absorb tick drift.
        if (dec_c) begin
          stop_chk_c = 1'b1;
          if (stop_cnt == STOP_LAST) begin
            done_c    = 1'b1;
            state_nxt = vote_c ? ST_IDLE : ST_BREAK;
          end
        end else if (end_c) begin
          stop_cnt_nxt = 1'b1;
        end
      end
      ST_BREAK: begin
        if (tick && rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample capture, shift register and per-frame error accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp       <= 2'b11;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      if (tick && (cnt == CNT_S0)) samp[0] <= rx_s;
      if (tick && (cnt == CNT_S1)) samp[1] <= rx_s;
      if (state == ST_IDLE) begin
        par_err_q  <= 1'b0;
        stop_err_q <= 1'b0;
      end
      if (shift_c)   shreg     <= {vote_c, shreg[DATA_BITS-1:1]};
      if (par_chk_c) par_err_q <= (^{shreg, vote_c}) ^ PAR_ODD;
      if (stop_chk_c && !vote_c) stop_err_q <= 1'b1;
    end
  end

  // One-entry output register with overrun detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      busy    <= (state_nxt != ST_IDLE);
      if (done_c) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= PAR_EN & par_err_q;
          frame_err  <= stop_err_q | ~vote_c;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 and 8E1 instances side by side.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned BIT_CLKS = 32;

  logic       clk, reset, tick;
  logic       rx_n, rx_e, ready_n, ready_e;
  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
  logic       ovr_n, ovr_e, busy_n, busy_e;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx_n), .data(data_n), .valid(valid_n),
    .ready(ready_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n), .busy(busy_n)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx_e), .data(data_e), .valid(valid_e),
    .ready(ready_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e), .busy(busy_e)
  );

  // Clock: posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick high across every other posedge (5, 25, 45 ...).
  initial begin
    tick = 1'b0;
    #2;
    forever begin
      tick = 1'b1;
      #10;
      tick = 1'b0;
      #10;
    end
  end

  // Output monitors: count valid / busy / overrun cycles and record the last word.
  int         vcnt_n = 0, vcnt_e = 0, ocnt_n = 0, bcnt_n = 0;
  logic [7:0] ldata_n = '0, ldata_e = '0;
  logic       lperr_n = 1'b0, lperr_e = 1'b0, lferr_n = 1'b0, lferr_e = 1'b0;

  always @(negedge clk) begin
    if (valid_n) begin
      vcnt_n  = vcnt_n + 1;
      ldata_n = data_n;
      lperr_n = perr_n;
      lferr_n = ferr_n;
    end
    if (valid_e) begin
      vcnt_e  = vcnt_e + 1;
      ldata_e = data_e;
      lperr_e = perr_e;
      lferr_e = ferr_e;
    end
    if (ovr_n)  ocnt_n = ocnt_n + 1;
    if (busy_n) bcnt_n = bcnt_n + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input logic e, input logic v);
    if (e) rx_e = v;
    else   rx_n = v;
  endtask

  // Start frames on a negedge whose following posedge carries a tick.
  task automatic align();
    @(negedge clk);
    if (($time % 64'd20) != 0) @(negedge clk);
  endtask

  task automatic send_bit(input logic e, input logic v);
    set_rx(e, v);
    hold(BIT_CLKS);
  endtask

  task automatic send_frame(input logic e, input logic [7:0] d, input logic p, input logic stop);
    align();
    send_bit(e, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(e, d[i]);
    if (e) send_bit(e, p);
    send_bit(e, stop);
    set_rx(e, 1'b1);
    hold(2 * BIT_CLKS);
  endtask

  typedef struct {
    logic       inst_e;
    logic [7:0] din;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int base, base_o, base_b, d;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

    rx_n = 1'b1; rx_e = 1'b1; ready_n = 1'b1; ready_e = 1'b1; reset = 1'b0;
    hold(5);
    chk("reset data",       32'(data_n),  0);
    chk("reset valid",      32'(valid_n), 0);
    chk("reset parity_err", 32'(perr_n),  0);
    chk("reset frame_err",  32'(ferr_n),  0);
    chk("reset overrun",    32'(ovr_n),   0);
    chk("reset busy",       32'(busy_n),  0);
    chk("reset valid_e",    32'(valid_e), 0);
    reset = 1'b1;
    hold(10);

    // Table-driven frames, ready held high.
    for (int i = 0; i < 9; i++) begin
      base = vecs[i].inst_e ? vcnt_e : vcnt_n;
      send_frame(vecs[i].inst_e, vecs[i].din, vecs[i].pbit, vecs[i].stop);
      d = (vecs[i].inst_e ? vcnt_e : vcnt_n) - base;
      chk($sformatf("vec%0d valid_cycles", i), d, 1);
      chk($sformatf("vec%0d data", i),
          32'(vecs[i].inst_e ? ldata_e : ldata_n), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d parity_err", i),
          32'(vecs[i].inst_e ? lperr_e : lperr_n), 32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d frame_err", i),
          32'(vecs[i].inst_e ? lferr_e : lferr_n), 32'(vecs[i].exp_ferr));
    end

    // False start: line low for 4 ticks only.
    align();
    base   = vcnt_n;
    base_b = bcnt_n;
    rx_n = 1'b0;
    hold(8);
    rx_n = 1'b1;
    hold(2 * BIT_CLKS);
    d = bcnt_n - base_b;
    chk("false_start busy_short", 32'((d > 0) && (d < 32)), 1);
    chk("false_start no_valid", vcnt_n - base, 0);
    chk("false_start idle", 32'(busy_n), 0);

    // Single-sample glitch at the middle of data bit 2 in frame 0x00.
    align();
    base = vcnt_n;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    rx_n = 1'b0; hold(18);
    rx_n = 1'b1; hold(1);
    rx_n = 1'b0; hold(13);
    for (int i = 3; i < 8; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    hold(2 * BIT_CLKS);
    chk("glitch valid_cycles", vcnt_n - base, 1);
    chk("glitch data", 32'(ldata_n), 0);

    // Line break for 20 bit times.
    align();
    base = vcnt_n;
    rx_n = 1'b0;
    hold(20 * BIT_CLKS);
    chk("break busy_held", 32'(busy_n), 1);
    chk("break one_word", vcnt_n - base, 1);
    chk("break data", 32'(ldata_n), 0);
    chk("break frame_err", 32'(lferr_n), 1);
    rx_n = 1'b1;
    hold(8);
    chk("break busy_released", 32'(busy_n), 0);
    hold(2 * BIT_CLKS);
    chk("break no_second_word", vcnt_n - base, 1);

    // Overrun with ready low, then reset mid-frame.
    ready_n = 1'b0;
    base_o  = ocnt_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    chk("overrun valid_held", 32'(valid_n), 1);
    chk("overrun data_kept", 32'(data_n), 32'h11);
    chk("overrun pulses", ocnt_n - base_o, 1);

    align();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("midframe busy", 32'(busy_n), 1);
    reset = 1'b0;
    hold(2);
    chk("midreset data",       32'(data_n),  0);
    chk("midreset valid",      32'(valid_n), 0);
    chk("midreset parity_err", 32'(perr_n),  0);
    chk("midreset frame_err",  32'(ferr_n),  0);
    chk("midreset overrun",    32'(ovr_n),   0);
    chk("midreset busy",       32'(busy_n),  0);
    rx_n = 1'b1;
    hold(2);
    reset = 1'b1;
    hold(10);
    ready_n = 1'b1;
    base = vcnt_n;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    chk("post_reset valid_cycles", vcnt_n - base, 1);
    chk("post_reset data", 32'(ldata_n), 32'h5A);
    chk("post_reset frame_err", 32'(lferr_n), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver that replaces the fixed 8N1 receiver. It recovers serial frames from `rx` using an oversampling tick enable and a majority-vote sampler, and supports configurable data width, parity and stop bits. Each received word, with its error flags, is delivered through a one-entry valid/ready output register. The block runs on the system clock and feeds the command/packet layer above it.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9, sent LSB first.
- `OVERSAMPLE`, default 16: ticks per bit, even, minimum 8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-low.
- `tick` input 1: oversample enable, one `clk` wide, OVERSAMPLE per bit time.
- `rx` input 1: asynchronous serial line; idles high.
- `data` output DATA_BITS: received word; held while `valid`.
- `valid` output 1: `data`/`parity_err`/`frame_err` hold a word.
- `ready` input 1: consumer accepts the word when `valid && ready`.
- `parity_err` output 1: parity mismatch for the held word (always 0 when PARITY=0).
- `frame_err` output 1: a stop bit sampled 0 for the held word.
- `overrun` output 1: one-`clk` pulse when a completed frame is dropped.
- `busy` output 1: FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All decisions use `rx_s`, and are evaluated only on `tick` cycles.
- Tick counter `cnt` has width clog2(OVERSAMPLE) and counts 0..OVERSAMPLE-1 within a bit. A bit advances on the tick where `cnt == OVERSAMPLE-1`.
- Bit value is the majority of the 3 samples at `cnt` = M-1, M, M+1, where M = OVERSAMPLE/2. The decision is taken at `cnt` = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a tick with `rx_s == 0`, go to START with `cnt` = 0.
  - START: at the decision point, a voted 1 is a false start and returns to IDLE. Otherwise wait to bit end, then go to DATA.
  - DATA: shift the voted bit into a shift register LSB first. After DATA_BITS bits, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: compare the voted bit with the computed parity. Odd parity: total count of ones (data + parity bit) is odd. Even parity: that count is even.
  - STOP: with 2 stop bits, the first stop bit runs a full period. On the decision point of the last stop bit, complete the frame and go to IDLE. The last stop bit is not waited out, which absorbs tick drift. If the last stop vote is 0, go to BREAK instead.
  - BREAK: wait for `rx_s == 1` on a tick, then go to IDLE. This prevents retriggering during a line break.
- Frame completion behaviour:
  - If the output is empty, or is being consumed in the same cycle (`valid && ready`), load `data`, `parity_err` and `frame_err`, and set `valid`.
  - Otherwise, drop the new frame, keep the held word unchanged, and pulse `overrun`.
- `frame_err` is set if any stop bit votes 0. Frames with errors are still delivered.

## Timing
- Reset values: `data` = 0, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. FSM = IDLE, `cnt` = 0, synchronizer = 1.
- Reset is asynchronous assert and synchronous release. Asserting reset mid-frame aborts the frame and discards any partial word.
- `valid` rises on the `clk` edge after the last-stop decision tick.
- End-to-end latency from the `rx` falling edge is about (1 + DATA_BITS + P + STOP_BITS - 1) × OVERSAMPLE + M + 2 ticks, plus 2 `clk` cycles of synchronizer delay. P = 1 if parity is enabled, else 0.
- `valid` falls on the `clk` edge after `valid && ready`. Completion and consumption in the same cycle keeps `valid` high and shows the new word.
- `ready` must not depend combinationally on `data`. `valid` does not depend combinationally on `ready`.
- `busy` is high from the IDLE→START transition until the return to IDLE, including BREAK.

## Test plan
- 8N1 at OVERSAMPLE = 16, send 0xA5 with `ready` = 1: `data` = 0xA5, `valid` high for 1 cycle, no errors.
- 8E1, send 0x03 with parity bit 1: `data` = 0x03, `parity_err` = 1. Send again with parity bit 0: `parity_err` = 0.
- Drive `rx` low for 4 ticks in IDLE: false start, return to IDLE, no `valid`, `busy` high for fewer than 16 ticks.
- Glitch a single sample at `cnt` = M of data bit 2 in frame 0x00: majority vote rejects it, `data` = 0x00.
- Break (rx low for 20 bit times): one word delivered with `data` = 0, `frame_err` = 1; `busy` stays high until `rx` returns high; no second word.
- Hold `ready` = 0 and send 0x11 then 0x22: `data` stays 0x11 and `overrun` pulses once. Assert `reset` mid-frame of a third byte: all outputs return to reset values, and the next frame (0x5A) is received correctly.
